o_feature_store: RTL
====================

Name: o_feature_store

Overview:
- Write-back counterpart of the input feature fetcher.
- Accepts CLP output words (Tm features per word) into an on-chip FIFO, then stores them to external memory over the data bus.
- A store instruction supplies destination address and word count; each accepted word is written to consecutive addresses, with ready backpressure.
- Sits between the CLP output path / instruction_decode and the external data bus port; reports done back to top_fsm.

Parameters:
- DATA_BUS_WIDTH, 128, width of CLP output word and external data bus (Tm*FEATURE_WIDTH == DATA_BUS_WIDTH).
- ADDR_WIDTH, 16, external feature address width.
- CNT_WIDTH, 8, store word-count width.
- FIFO_DEPTH_LOG2, 4, log2 of buffer depth (16 words).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- feature_valid  in  1  CLP output word valid this cycle.
- feature_in  in  DATA_BUS_WIDTH  CLP output word.
- store_enable  in  1  one-cycle store command pulse from instruction_decode.
- dst_addr  in  ADDR_WIDTH  first external address; sampled with store_enable.
- store_count  in  CNT_WIDTH  number of words to store; sampled with store_enable.
- o_data_bus_port  out  DATA_BUS_WIDTH  write data.
- o_feature_addr  out  ADDR_WIDTH  write address.
- o_feature_wr_en  out  1  write request.
- i_bus_ready  in  1  bus accepts write this cycle.
- store_busy  out  1  command in progress.
- store_done  out  1  one-cycle pulse on command completion.
- buf_level  out  FIFO_DEPTH_LOG2+1  FIFO occupancy, 0..16.
- buf_overflow  out  1  sticky: a valid word was dropped.

Behaviour:
- Reset (synchronous): FIFO emptied (pointers and level 0), state IDLE, all outputs 0, buf_overflow cleared. Reset mid-command abandons the command; no store_done is generated.
- Transfer condition: o_feature_wr_en && i_bus_ready. A transfer pops the FIFO head.
- Push: feature_valid && (level < 16 || transfer in the same cycle) writes feature_in at the tail.
  - The word is visible at the head no earlier than the next cycle.
  - feature_valid when full with no same-cycle pop drops the word and sets buf_overflow. buf_overflow stays set until rst.
- buf_level: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- Pointers wrap modulo 16.
- FSM:
  - IDLE: store_busy=0. On store_enable, latch addr←dst_addr and rem←store_count. Go to DONE if store_count==0, else WRITE.
  - WRITE: store_busy=1.
    - o_feature_wr_en = FIFO not empty (combinational from state and level).
    - o_data_bus_port = FIFO head when o_feature_wr_en=1, else 0.
    - o_feature_addr = addr.
    - On transfer: addr←addr+1 (wraps modulo 2^ADDR_WIDTH), rem←rem-1. If rem==1, go to DONE.
    - Empty FIFO stalls without timeout.
  - DONE: store_done=1 for exactly this cycle, store_busy=1, o_feature_wr_en=0. Go to IDLE next cycle.
- store_enable outside IDLE is ignored; no queuing.
- FIFO accepts pushes in every state. Words left after a command remain for the next command.
- Latency:
  - The earliest write is the cycle after store_enable, if the FIFO is non-empty.
  - Sustained throughput is 1 word/cycle with i_bus_ready held high.
  - store_done is asserted the cycle after the last transfer.
- o_data_bus_port and o_feature_addr must hold stable while o_feature_wr_en=1 and i_bus_ready=0.

Test Plan:
- Reset, then push 4 words A0..A3; store_enable with dst_addr=0x0100, count=4, i_bus_ready=1.
  - Required: writes at 0x0100..0x0103 with data A0..A3 on 4 consecutive cycles.
  - Required: store_done pulse on the 5th cycle; buf_level=0; busy then 0.
- Count=3 with i_bus_ready toggling 1,0,0,1,1.
  - Required: addr/data held during stalls; exactly 3 transfers; store_done once.
- Push 17 words with no command.
  - Required: buf_level=16; buf_overflow=1 after the 17th; a later count=16 store returns words 1..16 in order.
- dst_addr=0xFFFE, count=3.
  - Required: addresses 0xFFFE, 0xFFFF, 0x0000.
- store_enable count=0.
  - Required: store_done the next cycle, no o_feature_wr_en.
  - Second store_enable while busy: ignored, with no extra writes.
- Full FIFO with simultaneous pop and feature_valid.
  - Required: word accepted, level stays 16, overflow stays 0.
  - Assert rst mid-command: outputs 0, level 0, no store_done.

Source files
------------

// File: rtl/o_feature_store.sv
`default_nettype none
// ============================================================================
// Module   : o_feature_store
// Purpose  : Buffers CLP output words in a FIFO and writes them to consecutive
//            external addresses under a store command, with bus backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module o_feature_store #(
    parameter int DATA_BUS_WIDTH  = 128,
    parameter int ADDR_WIDTH      = 16,
    parameter int CNT_WIDTH       = 8,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       feature_valid,
    input  logic [DATA_BUS_WIDTH-1:0]  feature_in,
    input  logic                       store_enable,
    input  logic [ADDR_WIDTH-1:0]      dst_addr,
    input  logic [CNT_WIDTH-1:0]       store_count,
    output logic [DATA_BUS_WIDTH-1:0]  o_data_bus_port,
    output logic [ADDR_WIDTH-1:0]      o_feature_addr,
    output logic                       o_feature_wr_en,
    input  logic                       i_bus_ready,
    output logic                       store_busy,
    output logic                       store_done,
    output logic [FIFO_DEPTH_LOG2:0]   buf_level,
    output logic                       buf_overflow
);

    localparam int                   c_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] c_FULL = (FIFO_DEPTH_LOG2+1)'(c_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                       r_state, w_state_next;
    logic [ADDR_WIDTH-1:0]        r_addr, w_addr_next;
    logic [CNT_WIDTH-1:0]         r_rem, w_rem_next;

    logic [DATA_BUS_WIDTH-1:0]    r_mem [c_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]   r_wr_ptr, r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]     r_level;
    logic                         r_overflow;

    logic w_full, w_empty, w_wr_en, w_xfer, w_push, w_drop;

    assign w_full  = (r_level == c_FULL);
    assign w_empty = (r_level == '0);
    assign w_wr_en = (r_state == S_WRITE) && !w_empty;
    assign w_xfer  = w_wr_en && i_bus_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push  = feature_valid && (!w_full || w_xfer);
    assign w_drop  = feature_valid && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= feature_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_xfer})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_rem   <= w_rem_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_rem_next   = r_rem;
        case (r_state)
            S_IDLE: begin
                if (store_enable) begin
                    w_addr_next  = dst_addr;
                    w_rem_next   = store_count;
                    w_state_next = (store_count == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_xfer) begin
                    w_addr_next = r_addr + 1'b1;
                    w_rem_next  = r_rem - 1'b1;
                    if (r_rem == CNT_WIDTH'(1)) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_feature_wr_en = w_wr_en;
    assign o_data_bus_port = w_wr_en ? r_mem[r_rd_ptr] : '0;
    assign o_feature_addr  = (r_state == S_WRITE) ? r_addr : '0;
    assign store_busy      = (r_state != S_IDLE);
    assign store_done      = (r_state == S_DONE);
    assign buf_level       = r_level;
    assign buf_overflow    = r_overflow;

endmodule
`default_nettype wire
